fp_adder_scheduler: RTL and testbench

Shares one pipelined `floating_point_adder` instance between `NUM_REQ` requesters. Arbitration is round-robin. Each requester drives a valid/ready handshake carrying an operand pair. The scheduler issues at most one add per cycle, tags each add with its requester ID, and routes each result back to the originating requester. It sits between requester blocks and the adder. A drain mode quiesces the adder so it can be reconfigured or reset.

---
 rtl/fp_scheduler_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/fp_adder_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_fp_adder_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_scheduler_pkg.sv
// Shared types and width helpers for the floating-point adder scheduler.
// Tag ids are sized for the largest supported requester count (16).
package fp_scheduler_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int TAG_IDW = 4;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

    function automatic int fp_width(input int exp_w, input int frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request scan starting at a registered pointer.
// The pointer moves past the winner whenever a grant is issued.
module rr_arbiter
    import fp_scheduler_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = id_width(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     id_o
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = IDW'((int'(ptr_q) + off) % NUM_REQ);
            if (en_i && !found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                id_o       = idx;
            end
        end
    end

    always_comb begin
        if (id_o == IDW'(NUM_REQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = id_o + IDW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (|gnt_o) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fp_adder_scheduler.sv
// Shares one pipelined FP adder among NUM_REQ requesters, tagging each
// issued add with its requester id and routing the result back.
module fp_adder_scheduler
    import fp_scheduler_pkg::*;
#(
    parameter  int EXP_WIDTH     = 8,
    parameter  int FRAC_WIDTH    = 23,
    parameter  int NUM_REQ       = 4,
    parameter  int ADDER_LATENCY = 4,
    localparam int W             = fp_width(EXP_WIDTH, FRAC_WIDTH),
    localparam int IDW           = id_width(NUM_REQ),
    localparam int CW            = $clog2(ADDER_LATENCY + 3)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [NUM_REQ*W-1:0] req_a_i,
    input  logic [NUM_REQ*W-1:0] req_b_i,
    output logic [NUM_REQ-1:0]   rsp_valid_o,
    output logic [W-1:0]         rsp_data_o,
    output logic [W-1:0]         add_a_o,
    output logic [W-1:0]         add_b_o,
    output logic                 add_valid_o,
    input  logic [W-1:0]         add_result_i,
    input  logic                 add_valid_i,
    input  logic                 drain_i,
    output logic                 drain_done_o,
    output logic [CW-1:0]        inflight_o,
    output logic                 err_o
);

    // Extra stage covers the edge on which the adder samples its inputs.
    localparam int DEPTH = ADDER_LATENCY + 1;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_id;
    logic               arb_en;
    logic               accept;
    logic [W-1:0]       sel_a, sel_b;
    logic [W-1:0]       add_a_q, add_b_q;
    logic               add_valid_q;
    logic [IDW-1:0]     id_q;
    tag_t               tag_in, tag_out;
    tag_t               tag_q [DEPTH];
    logic               rsp_fire;
    logic [NUM_REQ-1:0] rsp_valid_d, rsp_valid_q;
    logic [W-1:0]       rsp_data_q;
    logic [CW-1:0]      inflight_d, inflight_q;
    logic               err_d, err_q;

    assign arb_en = (state_q == ARB) && !drain_i;
    assign accept = |gnt;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_valid_i),
        .en_i   (arb_en),
        .gnt_o  (gnt),
        .id_o   (gnt_id)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a_i[i*W +: W];
                sel_b = req_b_i[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            add_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            id_q        <= '0;
        end else begin
            add_valid_q <= accept;
            if (accept) begin
                add_a_q <= sel_a;
                add_b_q <= sel_b;
                id_q    <= gnt_id;
            end
        end
    end

    always_comb begin
        tag_in.valid = add_valid_q;
        tag_in.id    = TAG_IDW'(id_q);
    end

    assign tag_out = tag_q[DEPTH-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign rsp_fire = add_valid_i && tag_out.valid;

    always_comb begin
        rsp_valid_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = rsp_fire && (tag_out.id == TAG_IDW'(i));
        end
    end

    // A tag that meets no result still retires, so it is counted down too.
    always_comb begin
        inflight_d = inflight_q;
        unique case ({accept, tag_out.valid})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    assign err_d = err_q | (add_valid_i ^ tag_out.valid);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (rsp_fire) begin
                rsp_data_q <= add_result_i;
            end
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB: begin
                if (drain_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!drain_i) begin
                    state_d = ARB;
                end else if (inflight_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!drain_i) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    assign req_ready_o  = gnt;
    assign add_a_o      = add_a_q;
    assign add_b_o      = add_b_q;
    assign add_valid_o  = add_valid_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign inflight_o   = inflight_q;
    assign err_o        = err_q;
    assign drain_done_o = (state_q == DONE);

endmodule

// File: tb/tb_fp_adder_scheduler.sv
// Randomised bench: a latency-accurate adder model plus a scoreboard
// predicting grants, responses and occupancy from the scheduling rules.
module tb_fp_adder_scheduler;

    localparam int N  = 4;
    localparam int L  = 4;
    localparam int W  = 32;
    localparam int CW = $clog2(L + 3);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready_o;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   rsp_valid_o;
    logic [W-1:0]   rsp_data_o;
    logic [W-1:0]   add_a_o, add_b_o;
    logic           add_valid_o;
    logic [W-1:0]   add_result_i;
    logic           add_valid_i;
    logic           drain_i = 1'b0;
    logic           drain_done_o;
    logic [CW-1:0]  inflight_o;
    logic           err_o;

    logic [W-1:0] ra [N];
    logic [W-1:0] rb [N];
    int           left [N];
    logic         fixed_ops = 1'b0;
    logic         inj = 1'b0;
    logic [N-1:0] acc_v = '0;

    typedef struct {
        int         id;
        logic [W-1:0] data;
        longint     due;
    } exp_t;

    exp_t   sb [$];
    int     log_q [$];
    exp_t   e;
    int     mptr = 0;
    logic   drain_prev = 1'b0;
    logic [N-1:0] expg;
    longint ecount = 0;
    longint last_acc_edge = 0;
    longint last_rsp_edge = 0;
    int     tests_run = 0;
    int     tests_failed = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = ra[i];
            req_b[i*W +: W] = rb[i];
        end
    end

    fp_adder_scheduler #(
        .EXP_WIDTH(8), .FRAC_WIDTH(23), .NUM_REQ(N), .ADDER_LATENCY(L)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .add_a_o(add_a_o), .add_b_o(add_b_o), .add_valid_o(add_valid_o),
        .add_result_i(add_result_i), .add_valid_i(add_valid_i),
        .drain_i(drain_i), .drain_done_o(drain_done_o),
        .inflight_o(inflight_o), .err_o(err_o)
    );

    function automatic real s2r(input logic [31:0] x);
        logic [63:0] d;
        int          ex;
        if (x[30:23] == 8'd0) return 0.0;
        ex = int'(x[30:23]) + 896;
        d  = {x[31], ex[10:0], x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        int          ex;
        if (r == 0.0) return 32'd0;
        d  = $realtobits(r);
        ex = int'(d[62:52]) - 896;
        if (ex <= 0) return {d[63], 31'd0};
        if (ex >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], ex[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
        return r2s(s2r(a) + s2r(b));
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] ex;
        ex = 8'($urandom_range(110, 140));
        return {1'($urandom), ex, 23'($urandom)};
    endfunction

    function automatic logic [N-1:0] onehot(input int id);
        logic [N-1:0] g;
        g     = '0;
        g[id] = 1'b1;
        return g;
    endfunction

    function automatic logic [N-1:0] rr_pick(input int p, input logic [N-1:0] v);
        for (int off = 0; off < N; off++) begin
            if (v[(p + off) % N]) return onehot((p + off) % N);
        end
        return '0;
    endfunction

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Adder model: sampled one edge after issue, result L edges later.
    logic [W-1:0] ap_d [L+1];
    logic         ap_v [L+1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= L; i++) begin
                ap_v[i] <= 1'b0;
                ap_d[i] <= '0;
            end
        end else begin
            ap_v[0] <= add_valid_o;
            ap_d[0] <= fp_ref(add_a_o, add_b_o);
            for (int i = 1; i <= L; i++) begin
                ap_v[i] <= ap_v[i-1];
                ap_d[i] <= ap_d[i-1];
            end
        end
    end

    assign add_valid_i  = ap_v[L] | inj;
    assign add_result_i = ap_d[L];

    always @(posedge clk) ecount <= ecount + 1;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_v[i]) begin
                if (left[i] > 0) left[i]--;
                if (!fixed_ops) begin
                    ra[i] = rand_fp();
                    rb[i] = rand_fp();
                end
            end
            req_valid[i] = (left[i] > 0);
        end
    end

    always @(negedge clk) begin
        acc_v = '0;
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == ecount) begin
                e = sb.pop_front();
                check("rsp_valid", rsp_valid_o, onehot(e.id));
                check("rsp_data", rsp_data_o, e.data);
                last_rsp_edge = ecount;
            end else begin
                check("rsp_idle", rsp_valid_o, 0);
            end
            check("inflight", inflight_o, sb.size());
            expg = (!drain_i && !drain_prev) ? rr_pick(mptr, req_valid) : '0;
            check("grant", req_ready_o, expg);
            acc_v = req_valid & req_ready_o;
            for (int i = 0; i < N; i++) begin
                if (acc_v[i]) begin
                    sb.push_back('{id: i, data: fp_ref(ra[i], rb[i]), due: ecount + L + 3});
                    mptr = (i + 1) % N;
                    log_q.push_back(i);
                    last_acc_edge = ecount + 1;
                end
            end
            drain_prev = drain_i;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        drain_i = 1'b0;
        inj = 1'b0;
        for (int i = 0; i < N; i++) left[i] = 0;
        sb.delete();
        log_q.delete();
        mptr = 0;
        drain_prev = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        logic idle;
        idle = 1'b0;
        for (int c = 0; c < 300 && !idle; c++) begin
            @(negedge clk); #1;
            idle = (req_valid == '0) && (sb.size() == 0);
            for (int i = 0; i < N; i++) if (left[i] != 0) idle = 1'b0;
        end
        check(tag, idle, 1);
    endtask

    task automatic wait_log(input string tag, input int n);
        for (int c = 0; c < 40 && log_q.size() < n; c++) begin
            @(negedge clk); #1;
        end
        check(tag, log_q.size() >= n, 1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rb[i] = '0;
            left[i] = 0;
        end
        do_reset();

        // single op on requester 2
        @(negedge clk); #1;
        fixed_ops = 1'b1;
        ra[2] = 32'h3F80_0000;
        rb[2] = 32'h4000_0000;
        left[2] = 1;
        wait_log("single_acc", 1);
        for (int c = 0; c < 20 && rsp_valid_o == '0; c++) begin
            @(negedge clk); #1;
        end
        check("single_vld", rsp_valid_o, 4'b0100);
        check("single_data", rsp_data_o, 32'h4040_0000);
        check("single_lat", ecount - last_acc_edge, L + 2);
        wait_idle("single_idle");
        fixed_ops = 1'b0;

        // round-robin from pointer 0
        do_reset();
        @(negedge clk); #1;
        for (int i = 0; i < N; i++) left[i] = 2;
        wait_log("rr_acc", 8);
        for (int i = 0; i < 8; i++) check("rr_order", log_q[i], i % N);
        wait_idle("rr_idle");

        // fairness after skip: pointer parked at 1
        @(negedge clk); #1;
        left[0] = 1;
        wait_idle("skip_prep");
        log_q.delete();
        left[0] = 1;
        left[3] = 1;
        wait_log("skip_acc", 2);
        check("skip_first", log_q[0], 3);
        check("skip_second", log_q[1], 0);
        wait_idle("skip_idle");

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) left[i] = $urandom_range(0, 6);
            wait_idle("rand_idle");
        end
        check("err_clean", err_o, 0);

        // drain with three ops in flight
        log_q.delete();
        left[0] = 3;
        for (int c = 0; c < 20 && sb.size() < 3; c++) begin
            @(negedge clk); #1;
        end
        check("drain_prep", sb.size(), 3);
        left[1] = 5;
        @(posedge clk); #1 drain_i = 1'b1;
        @(negedge clk); #1;
        check("drain_gate", req_ready_o, 0);
        check("drain_inflight", inflight_o, 3);
        for (int c = 0; c < 30 && !drain_done_o; c++) begin
            @(negedge clk); #1;
        end
        check("drain_done", drain_done_o, 1);
        check("drain_empty", sb.size(), 0);
        check("drain_done_lat", ecount - last_rsp_edge, 1);
        @(posedge clk); #1 drain_i = 1'b0;
        @(negedge clk); #1;
        check("drain_hold", req_ready_o, 0);
        @(negedge clk); #1;
        check("regrant", req_ready_o, 4'b0010);
        wait_idle("drain_idle");

        // untagged result
        @(negedge clk); #1 inj = 1'b1;
        @(negedge clk); #1 inj = 1'b0;
        check("err_set", err_o, 1);
        repeat (3) @(negedge clk);
        #1 check("err_sticky", err_o, 1);

        // asynchronous reset clears everything
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check("rst_err", err_o, 0);
        check("rst_outs", {req_ready_o, rsp_valid_o, rsp_data_o, add_valid_o, add_a_o,
                           add_b_o, drain_done_o, inflight_o, err_o}, 0);
        do_reset();

        // reset with two ops in flight
        @(negedge clk); #1;
        left[0] = 2;
        for (int c = 0; c < 20 && sb.size() < 2; c++) begin
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
        check("mid_inflight", inflight_o, 2);
        do_reset();
        repeat (L + 8) @(negedge clk);
        #1;
        check("mid_after_inflight", inflight_o, 0);
        check("mid_after_err", err_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
